// File: rtl/otp_checker.sv
// otp_checker: OTP session controller. Captures the generator's BCD OTP on
// request, collects four keypad digits, and reports grant/deny/timeout, with
// a per-session attempt limit and a lockout period after the attempts run out.
module otp_checker #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int LOCK_CYCLES    = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        gen_req,
  input  logic [15:0] otp_in,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  output logic [15:0] otp_out,
  output logic        busy,
  output logic        grant,
  output logic        deny,
  output logic        timeout,
  output logic        locked,
  output logic [1:0]  attempts_left
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    CHECK = 2'd2,
    LOCK  = 2'd3
  } state_t;

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] LOCK_LAST  = 16'(LOCK_CYCLES - 1);
  localparam logic [1:0]  ATT_INIT   = 2'(MAX_ATTEMPTS);

  state_t      state, state_nx;
  logic [15:0] otp_reg, otp_reg_nx;
  logic [15:0] entry_reg, entry_reg_nx;
  logic [2:0]  digit_cnt, digit_cnt_nx;
  logic [15:0] timer, timer_nx;
  logic [15:0] lock_cnt, lock_cnt_nx;
  logic [1:0]  att_nx;
  logic        grant_nx, deny_nx, timeout_nx;
  logic        expired, digit_ok;

  // Session expires on the cycle where the timer holds its last value.
  assign expired  = (timer == TIMER_LAST);
  assign digit_ok = key_valid && (key_digit <= 4'd9);

  // The display mirrors the captured OTP; it is cleared whenever no session is active.
  assign otp_out = otp_reg;

  // Next-state and next-register logic; timeout outranks digits and check results.
  always_comb begin
    state_nx     = state;
    otp_reg_nx   = otp_reg;
    entry_reg_nx = entry_reg;
    digit_cnt_nx = digit_cnt;
    timer_nx     = timer;
    lock_cnt_nx  = lock_cnt;
    att_nx       = attempts_left;
    grant_nx     = 1'b0;
    deny_nx      = 1'b0;
    timeout_nx   = 1'b0;

    case (state)
      IDLE: begin
        if (gen_req) begin
          otp_reg_nx   = otp_in;
          entry_reg_nx = 16'h0000;
          att_nx       = ATT_INIT;
          digit_cnt_nx = 3'd0;
          timer_nx     = 16'd0;
          state_nx     = ENTRY;
        end else begin
          state_nx = IDLE;
        end
      end

      ENTRY: begin
        timer_nx = timer + 16'd1;
        if (expired) begin
          timeout_nx = 1'b1;
          otp_reg_nx = 16'h0000;
          att_nx     = 2'd0;
          state_nx   = IDLE;
        end else if (digit_ok) begin
          entry_reg_nx = {entry_reg[11:0], key_digit};
          digit_cnt_nx = digit_cnt + 3'd1;
          if (digit_cnt == 3'd3) begin
            state_nx = CHECK;
          end else begin
            state_nx = ENTRY;
          end
        end else begin
          state_nx = ENTRY;
        end
      end

      CHECK: begin
        timer_nx = timer + 16'd1;
        if (expired) begin
          timeout_nx = 1'b1;
          otp_reg_nx = 16'h0000;
          att_nx     = 2'd0;
          state_nx   = IDLE;
        end else if (entry_reg == otp_reg) begin
          grant_nx   = 1'b1;
          otp_reg_nx = 16'h0000;
          att_nx     = 2'd0;
          state_nx   = IDLE;
        end else if (attempts_left > 2'd1) begin
          deny_nx      = 1'b1;
          att_nx       = attempts_left - 2'd1;
          digit_cnt_nx = 3'd0;
          entry_reg_nx = 16'h0000;
          state_nx     = ENTRY;
        end else begin
          att_nx      = 2'd0;
          otp_reg_nx  = 16'h0000;
          lock_cnt_nx = 16'd0;
          state_nx    = LOCK;
        end
      end

      LOCK: begin
        if (lock_cnt == LOCK_LAST) begin
          state_nx = IDLE;
        end else begin
          lock_cnt_nx = lock_cnt + 16'd1;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; reset clears everything including pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      otp_reg       <= 16'h0000;
      entry_reg     <= 16'h0000;
      digit_cnt     <= 3'd0;
      timer         <= 16'd0;
      lock_cnt      <= 16'd0;
      attempts_left <= 2'd0;
      grant         <= 1'b0;
      deny          <= 1'b0;
      timeout       <= 1'b0;
      busy          <= 1'b0;
      locked        <= 1'b0;
    end else begin
      state         <= state_nx;
      otp_reg       <= otp_reg_nx;
      entry_reg     <= entry_reg_nx;
      digit_cnt     <= digit_cnt_nx;
      timer         <= timer_nx;
      lock_cnt      <= lock_cnt_nx;
      attempts_left <= att_nx;
      grant         <= grant_nx;
      deny          <= deny_nx;
      timeout       <= timeout_nx;
      busy          <= (state_nx != IDLE);
      locked        <= (state_nx == LOCK);
    end
  end

endmodule

// File: doc/otp_checker.md
# otp_checker

Session controller downstream of the LFSR OTP generator. On a user request it captures the current 4-digit BCD OTP and then collects four keypad digits. It compares the entry against the captured OTP and reports grant/deny, with limits on attempts, a session timeout and a lockout period. It is the decision stage of the OTP authenticator and drives the display and result indicators.

## Interface
- TIMEOUT_CYCLES, 1000: session length in clk cycles, counted from OTP capture; range 2..65535.
- MAX_ATTEMPTS, 3: wrong entries allowed per session; range 1..3.
- LOCK_CYCLES, 500: lockout duration in clk cycles after the attempts are exhausted; range 1..65535.
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- gen_req  input  1  start-session request; sampled only in IDLE.
- otp_in  input  16  BCD OTP from the generator, one digit per nibble, [15:12] most significant.
- key_valid  input  1  one-cycle strobe: key_digit is valid this cycle.
- key_digit  input  4  entered digit; values 10..15 are invalid.
- otp_out  output  16  captured OTP for display; 16'h0000 when no session is active.
- busy  output  1  high whenever state is not IDLE.
- grant  output  1  one-cycle pulse: the entry matched.
- deny  output  1  one-cycle pulse: the entry mismatched and attempts remain.
- timeout  output  1  one-cycle pulse: the session expired.
- locked  output  1  level, high for the whole LOCK state.
- attempts_left  output  2  remaining attempts in the current session.

## Operation
- States: IDLE, ENTRY, CHECK, LOCK. Reset forces IDLE.
- Reset values: every output is 0. Internal registers otp_reg, entry_reg, digit_cnt, timer and lock counter are also 0.
- IDLE, on gen_req=1:
  - otp_reg <= otp_in; otp_out shows otp_reg from the next cycle.
  - attempts_left <= MAX_ATTEMPTS; digit_cnt <= 0; timer <= 0.
  - Next state: ENTRY.
- ENTRY:
  - The timer increments every cycle.
  - A key_valid with key_digit<=9 shifts the digit into entry_reg (entry_reg <= {entry_reg[11:0], key_digit}) and increments digit_cnt. The first digit ends up in [15:12].
  - A key_valid with key_digit>9 is ignored: no shift, no count.
  - When the 4th valid digit is accepted, the next state is CHECK.
- Timeout: in ENTRY or CHECK, when timer reaches TIMEOUT_CYCLES-1:
  - Pulse timeout; clear otp_reg, otp_out and attempts_left; go to IDLE.
  - Timeout has priority over a simultaneous key_valid or CHECK result.
- CHECK (one cycle; the timer keeps running):
  - entry_reg==otp_reg: pulse grant; clear otp_reg and attempts_left; go to IDLE.
  - Mismatch with attempts_left>1: decrement attempts_left; pulse deny; clear digit_cnt and entry_reg; return to ENTRY. The timer is not restarted.
  - Mismatch with attempts_left==1: attempts_left <= 0; clear otp_reg; go to LOCK. No deny pulse.
- LOCK: locked=1 and busy=1 for exactly LOCK_CYCLES cycles, then IDLE.
- Inputs ignored outside their states:
  - gen_req in ENTRY, CHECK or LOCK.
  - key_valid in IDLE, CHECK or LOCK.
- grant, deny and timeout are mutually exclusive and are never asserted in the same cycle as reset.

## Timing
- Session start: gen_req sampled at edge E. From E+1: busy=1, otp_out=otp_in as sampled at E, attempts_left=MAX_ATTEMPTS.
- Compare:
  - 4th digit sampled at edge D. State is CHECK for the cycle after D.
  - grant, deny or locked is registered at edge D+1. Pulses are high for exactly one cycle, D+1 to D+2.
  - After deny, a new digit is accepted from edge D+2 onward.
- Timeout: with capture at E, timeout is high for one cycle starting at edge E+TIMEOUT_CYCLES; busy falls at that same edge.
- Lock: locked rises at D+1, falls at D+1+LOCK_CYCLES; busy falls at that same edge.
- Reset mid-session (any state): at the reset edge, all outputs return to reset values and any in-flight pulse is suppressed.
- Back-to-back: a gen_req in the first IDLE cycle after grant or timeout starts a new session normally.

## Test plan
- Correct entry: otp_in=16'h0241, gen_req, keys 0,2,4,1 -> grant single-cycle pulse two edges after key 1; otp_out 16'h0241 during the session, then 16'h0000; busy low after the grant.
- Invalid key filtering: otp_in=16'h7305, keys 7,12,3,0,15,5 -> 12 and 15 ignored, grant asserted; deny never asserted.
- Retry then succeed: MAX_ATTEMPTS=3, otp 16'h1234, entry 1,2,3,5 -> deny pulse, attempts_left=2; then 1,2,3,4 -> grant.
- Lockout: three wrong entries -> deny twice, then locked=1 for exactly LOCK_CYCLES cycles with no third deny; attempts_left=0; gen_req during lock ignored; busy drops when the lock ends.
- Timeout: TIMEOUT_CYCLES=20, two digits entered, then idle -> timeout pulse at capture edge + 20; otp_out=0; a key_valid landing on the expiry cycle is ignored.
- Reset mid-entry: after 3 digits assert reset for one cycle -> all outputs 0, state IDLE; key_valid afterwards causes no response until the next gen_req.
